axis_fifo_arbiter: RTL
======================

# axis_fifo_arbiter

Frame-atomic round-robin arbiter that merges `NUM_PORTS` AXI-Stream sources into the single sink of an `axis_fifo_wrapper`. It locks a grant from the first beat to `tlast` so frames never interleave. It issues a new grant only when the downstream FIFO reports at least `MIN_FREE` free entries. It sits between the packet producers and the shared FIFO, so one FIFO serves several requesters.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of input streams, 2..16.
- `DATA_WIDTH`, 8: tdata width.
- `KEEP_WIDTH`, (DATA_WIDTH+7)/8: tkeep width.
- `USER_WIDTH`, 1: tuser width.
- `FIFO_DEPTH`, 256: depth of the downstream FIFO.
- `MIN_FREE`, 16: free entries required before a grant is issued.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `s_axis_tdata` in NUM_PORTS*DATA_WIDTH: port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tkeep` in NUM_PORTS*KEEP_WIDTH: per-port tkeep.
- `s_axis_tvalid` in NUM_PORTS: per-port tvalid.
- `s_axis_tready` out NUM_PORTS: per-port tready.
- `s_axis_tlast` in NUM_PORTS: per-port tlast.
- `s_axis_tuser` in NUM_PORTS*USER_WIDTH: per-port tuser.
- `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tvalid`, `m_axis_tready` (in), `m_axis_tlast`, `m_axis_tuser`: merged stream to the FIFO sink.
- `fifo_depth` in $clog2(FIFO_DEPTH)+1: FIFO `status.depth`.
- `grant_port` out $clog2(NUM_PORTS): index of the port currently granted.
- `busy` out 1: high while a frame is locked.

## Operation
States:
- IDLE: no port granted.
  - If any `s_axis_tvalid[i]` is high and `FIFO_DEPTH - fifo_depth >= MIN_FREE`: choose the winner, register `grant_port`, go to XFER.
  - Otherwise stay in IDLE.
- XFER: the granted port is muxed straight through.
  - `m_axis_*` = `s_axis_*[grant_port]`.
  - `s_axis_tready[grant_port]` = `m_axis_tready`; all other treadys are 0.
  - On a handshake with `tlast`=1: set `last_grant <= grant_port` and go to IDLE.

Arbitration rules:
- Winner is the first requesting port searched circularly from `last_grant+1`, wrapping at `NUM_PORTS-1` to 0.
- The space check applies only at grant time. Mid-frame FIFO backpressure comes through `m_axis_tready` alone.
- A port that drops tvalid mid-frame keeps the lock. The arbiter waits indefinitely for `tlast`.

Outputs outside XFER:
- `m_axis_tvalid`=0.
- All `s_axis_tready`=0.
- `m_axis_tdata`/`tkeep`/`tlast`/`tuser` driven to 0.

## Timing
Reset values:
- State IDLE.
- `grant_port`=0, `busy`=0.
- `last_grant`=NUM_PORTS-1, so port 0 has first priority.
- All treadys 0; `m_axis_tvalid`=0.

Latency and throughput:
- Requests seen in IDLE at cycle N: XFER starts at N+1, and the first beat can transfer at N+1.
- Zero added latency per beat (combinational mux path).
- One idle bubble per frame: the cycle after `tlast`.
- A single-beat frame occupies 2 cycles.

Boundary cases:
- `tlast` handshake and a new request in the same cycle: the new grant is decided in the following IDLE cycle using the updated `last_grant`.
- `fifo_depth == FIFO_DEPTH - MIN_FREE + 1`: no grant. The arbiter stays in IDLE until space reaches `MIN_FREE`.
- `reset` mid-frame: return to IDLE the next cycle and drop the partial frame. The FIFO is expected to be reset together with the arbiter.

## Configuration
- `AXIS_FIFO_ARB_FRAME_COUNT_EN` defined:
  - Adds output `frame_count`, width NUM_PORTS*16.
  - Each counter increments on every `tlast` handshake from its port.
  - Counters wrap at 16'hFFFF to 0 and clear on reset.
- Macro undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package `axis_fifo_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t`.
  - Function `rr_pick(req, last)` returning the winner index.
- Sub-module `rr_priority_select`: purely combinational circular priority encoder (req vector, last index → winner index, valid).

## Test plan
- Reset, then single frame on port 2 (3 beats, tready=1) → grant_port=2 at cycle 1, beats on cycles 1-3, busy low at cycle 4.
- All 4 ports each hold a 2-beat frame → frames emitted in order 0,1,2,3, no interleave, 1 bubble between frames.
- Port 1 frame in progress, port 0 requests → port 0 stays at tready=0 until port 1's tlast handshake, then granted next.
- `fifo_depth`=241 with FIFO_DEPTH=256, MIN_FREE=16, port 0 valid → no grant; at `fifo_depth`=240 → grant the next cycle.
- `m_axis_tready` toggled 1/0 during a 4-beat frame → each beat transferred exactly once in order; tready mirrored only on the granted port.
- `reset` asserted mid-frame → busy=0, treadys 0 the next cycle; with `AXIS_FIFO_ARB_FRAME_COUNT_EN`, counters read 0.

Source files
------------

// File: rtl/axis_fifo_arb_pkg.sv
// Shared types and the round-robin pick function for axis_fifo_arbiter.
package axis_fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_XFER} arb_state_t;

  localparam int unsigned MAX_PORTS = 16;

  // First set bit of req searched circularly from last+1 over n ports; returns last if none.
  function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned win;
    int unsigned idx;
    logic        found;
    win   = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
      if (i <= n) begin
        idx = (last + i) % n;
        if (!found && req[4'(idx)]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational circular priority encoder: winner is the first requester after last.
module rr_priority_select
  import axis_fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  int unsigned pick;

  always_comb begin
    pick   = rr_pick(MAX_PORTS'(req), 32'(last), NUM_PORTS);
    winner = IDX_W'(pick);
    valid  = |req;
  end

endmodule

// File: rtl/axis_fifo_arbiter.sv
// Frame-atomic round-robin AXI-Stream merger feeding a shared FIFO.
// Optional per-port frame counters when AXIS_FIFO_ARB_FRAME_COUNT_EN is defined.
module axis_fifo_arbiter
  import axis_fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned MIN_FREE   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  input  logic [$clog2(FIFO_DEPTH):0]      fifo_depth,
`ifdef AXIS_FIFO_ARB_FRAME_COUNT_EN
  output logic [NUM_PORTS*16-1:0]          frame_count,
`endif
  output logic [$clog2(NUM_PORTS)-1:0]     grant_port,
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] last_grant, last_grant_next;
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] sel_winner;
  logic             sel_valid;
  logic             space_ok;
  logic             beat_hs;
  logic             last_hs;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_select (
    .req    (s_axis_tvalid),
    .last   (last_grant),
    .winner (sel_winner),
    .valid  (sel_valid)
  );

  // Addition form avoids underflow if the FIFO ever reports more than FIFO_DEPTH.
  assign space_ok = (32'(fifo_depth) + MIN_FREE) <= FIFO_DEPTH;
  assign beat_hs  = (state == ARB_XFER) && m_axis_tvalid && m_axis_tready;
  assign last_hs  = beat_hs && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      grant_port <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      grant_port <= grant_next;
      last_grant <= last_grant_next;
      busy       <= (state_next == ARB_XFER);
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant_port;
    last_grant_next = last_grant;
    case (state)
      ARB_IDLE: begin
        if (sel_valid && space_ok) begin
          state_next = ARB_XFER;
          grant_next = sel_winner;
        end
      end
      ARB_XFER: begin
        if (last_hs) begin
          state_next      = ARB_IDLE;
          last_grant_next = grant_port;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Zero-latency pass-through of the locked port; everything quiet outside XFER.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    if (state == ARB_XFER) begin
      m_axis_tdata              = s_axis_tdata[32'(grant_port)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep              = s_axis_tkeep[32'(grant_port)*KEEP_WIDTH +: KEEP_WIDTH];
      m_axis_tvalid             = s_axis_tvalid[grant_port];
      m_axis_tlast              = s_axis_tlast[grant_port];
      m_axis_tuser              = s_axis_tuser[32'(grant_port)*USER_WIDTH +: USER_WIDTH];
      s_axis_tready[grant_port] = m_axis_tready;
    end
  end

`ifdef AXIS_FIFO_ARB_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (last_hs) begin
      frame_count[32'(grant_port)*16 +: 16] <= frame_count[32'(grant_port)*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule
